// File: rtl/keypad_scanner.sv
// keypad_scanner: drives one-hot keypad columns, attributes debounced row
//   pulses to the active column, suppresses repeats while a key is held, and
//   queues 4-bit key codes in a first-word-fall-through (FWFT) FIFO.
// Latency: a key code is visible on key_code/key_valid one cycle after the
//   edge that samples the accepted buttonMux pulse.
// Backpressure: key_ready pops the head entry. An event that arrives while the
//   FIFO is full and not popping is dropped, its held bit stays clear so it is
//   seen again on a later pass, and the sticky overflow flag is set.
// Ports: clk/rst (synchronous, active high); en scan enable; row_level raw
//   rows, used for release detection; buttonMux debounced rising-edge pulses;
//   col one-hot column drive; deb_en debouncer enable; key_valid, key_code and
//   key_ready form the consumer handshake; overflow is the sticky drop flag.
module keypad_scanner #(
  parameter int DWELL_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] row_level,
  input  logic [3:0] buttonMux,
  output logic [3:0] col,
  output logic       deb_en,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready,
  output logic       overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [7:0]    DWELL_LAST = 8'(DWELL_CYCLES - 1);
  localparam logic [7:0]    SETTLE_C   = 8'(SETTLE_CYCLES);
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

  // IDLE covers the first enabled cycle after en was low: the column is
  // re-driven from 0 with the dwell counter held at 0, so column 0 gets a
  // full dwell on restart.
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state, state_nxt;

  logic [1:0]  c, c_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        scan, in_window, dwell_end;
  logic [3:0]  held_row, cand;
  logic        hit;
  logic [1:0]  sel_r;
  logic [15:0] key_state, key_state_nxt;

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, push, pop, drop;

  always_comb begin
    state_nxt = state;
    if (!en) state_nxt = IDLE;
    else     state_nxt = SCAN;
  end

  assign scan      = en && (state == SCAN);
  assign in_window = scan && (cnt >= SETTLE_C);
  assign dwell_end = scan && (cnt == DWELL_LAST);

  // Only rows whose held bit is clear can raise an event.
  assign held_row = key_state[{c, 2'b00} +: 4];
  assign cand     = buttonMux & ~held_row & {4{in_window}};

  // Lowest candidate row wins; the others are retried on a later pass.
  always_comb begin
    hit   = 1'b0;
    sel_r = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (cand[r]) begin
        hit   = 1'b1;
        sel_r = 2'(r);
      end
    end
  end

  assign key_valid = (count != '0);
  assign key_code  = key_valid ? mem[rd_ptr] : 4'd0;
  assign pop       = key_valid && key_ready;
  assign full      = (count == DEPTH_C);
  // A same-cycle pop frees the slot, so a full FIFO can still accept.
  assign push      = hit && (!full || pop);
  assign drop      = hit && full && !pop;

  always_comb begin
    cnt_nxt = cnt + 8'd1;
    c_nxt   = c;
    if (cnt == DWELL_LAST) begin
      cnt_nxt = 8'd0;
      c_nxt   = c + 2'd1;
    end
  end

  // Release is applied before the set, so a key accepted on the last dwell
  // cycle stays held even if its row level is already low.
  always_comb begin
    key_state_nxt = key_state;
    if (dwell_end) begin
      for (int r = 0; r < 4; r++) begin
        if (!row_level[r]) key_state_nxt[{c, 2'(r)}] = 1'b0;
      end
    end
    if (push) key_state_nxt[{c, sel_r}] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      c         <= 2'd0;
      cnt       <= 8'd0;
      col       <= 4'b0001;
      deb_en    <= 1'b0;
      key_state <= 16'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      key_state <= key_state_nxt;
      if (!en) begin
        c      <= 2'd0;
        cnt    <= 8'd0;
        col    <= 4'b0000;
        deb_en <= 1'b0;
      end else if (state == IDLE) begin
        c      <= 2'd0;
        cnt    <= 8'd0;
        col    <= 4'b0001;
        deb_en <= 1'b0;
      end else begin
        c      <= c_nxt;
        cnt    <= cnt_nxt;
        col    <= 4'b0001 << c_nxt;
        deb_en <= (cnt_nxt >= SETTLE_C);
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {c, sel_r};
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Column-drive and key-event side of the 4x4 elevator keypad interface, pairing with the row debouncer.
- Drives one-hot columns and gates the debouncer enable around each column switch.
- Attributes debounced row rising-edge pulses (buttonMux) to the active column and suppresses repeats while a key is held.
- Queues 4-bit key codes in a small first-word-fall-through (FWFT) FIFO for the floor-request logic, using a valid/ready handshake.

Parameters:
DWELL_CYCLES, 16, clock cycles each column is driven; legal range SETTLE_CYCLES+2..255
SETTLE_CYCLES, 4, cycles at the start of each dwell with deb_en low and pulses ignored; must be >=3 to cover debouncer pipeline depth
FIFO_DEPTH, 4, key-code queue entries; power of 2, >=2

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  scan enable; low halts scanning, FIFO still drains
row_level  in  4  synchronized raw row levels, used only for release detection
buttonMux  in  4  debouncer rising-edge pulses, one cycle per edge
col  out  4  one-hot column drive
deb_en  out  1  enable to the debouncer
key_valid  out  1  FIFO non-empty
key_code  out  4  head entry, {col_idx[1:0], row_idx[1:0]}
key_ready  in  1  consumer pop; pop occurs when key_valid && key_ready
overflow  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset, synchronous, on the cycle rst is sampled high:
  - col=4'b0001, deb_en=0, key_valid=0, key_code=0, overflow=0.
  - Column index c=0, dwell counter cnt=0, 16-bit held bitmap key_state=0, FIFO emptied.
  - Reset mid-operation discards any queued codes.
- Scan, while en=1:
  - cnt counts 0..DWELL_CYCLES-1. At DWELL_CYCLES-1, cnt wraps to 0 and c advances 0→1→2→3→0.
  - col=onehot(c), registered; it changes on the same edge as cnt wraps.
- en=0:
  - col=4'b0000, deb_en=0, c=0, cnt=0; key_state retained.
  - On re-enable, scanning restarts at column 0, cnt=0.
- deb_en = en && (cnt >= SETTLE_CYCLES), registered-consistent with cnt.
- Acceptance window is cnt >= SETTLE_CYCLES; buttonMux is ignored outside it.
- In-window event selection:
  - Candidate rows: r where buttonMux[r]=1 and key_state[c*4+r]=0.
  - If candidates exist, the lowest r is selected. Others are dropped this cycle and are re-detected on a later pass, since their bits stay clear.
  - Pulses on rows whose held bit is already set are ignored (no repeat while held).
- Push on a selected event:
  - Pushes {c[1:0], r[1:0]} and sets key_state[c*4+r].
  - Full FIFO with no same-cycle pop: no push, bit not set, overflow<=1.
  - Full FIFO with a same-cycle pop: push accepted, occupancy unchanged.
- Release: at cnt==DWELL_CYCLES-1 with en=1, for each r with row_level[r]=0, clear key_state[c*4+r].
- FIFO is FWFT:
  - key_valid = occupancy!=0, key_code = head entry (0 when empty).
  - Pop on key_valid && key_ready; key_ready while empty has no effect.
  - Push-to-empty: key_valid rises the cycle after the push edge.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- overflow clears only on rst.

Test Plan:
1. Bench uses DWELL_CYCLES=8, SETTLE_CYCLES=4. Release rst with en=1 → col sequence 0001 (8 cycles), 0010, 0100, 1000, then 0001 at cycle 32; deb_en high only on cnt 4..7 of each dwell.
2. Key press:
   - Stimulus: buttonMux=0010 pulse at cnt=5 in column 2; row_level[1] held high.
   - Response: key_valid=1, key_code=4'b1001 next cycle.
   - Hold: the same pulse on later passes queues nothing.
   - Release: drop row_level[1] → bit clears at cnt=7; the next pulse queues 1001 again.
3. Settle-window and simultaneous pulses:
   - buttonMux=0001 at cnt=2 → ignored, FIFO stays empty.
   - buttonMux=1010 at cnt=6 in column 0 → code 0001 queued; code 0011 is queued on the next pass's in-window pulse.
4. Overflow: 5 distinct key events with key_ready=0 → 4 codes queued, overflow=1; drain → codes pop in push order; overflow stays 1.
5. Full with pop:
   - FIFO full, key_ready=1 on the same cycle a new event arrives → event accepted, occupancy stays 4, overflow stays 0.
   - rst mid-stream → key_valid=0, col=0001, overflow=0.
6. en=0 mid-dwell → col=0000, deb_en=0, pulses ignored, queued codes still drain; en=1 → col=0001 with cnt restarting at 0.
